acc_c_responder: RTL and testbench
==================================

Name: acc_c_responder

Overview:
- Accelerator-side endpoint of the ACC_C offload protocol. It terminates one extended-ID master port of an interconnect level.
- Accepts offloaded requests and forwards operands to a local accelerator core over a simple valid/ready pair.
- Records each request's extended ID in order and re-attaches it to the core's in-order result. The response then routes back through the response crossbar to the right requester.
- One instance sits in front of each accelerator unit.

Parameters:
- DataWidth, 32, operand/result width.
- HierAddrWidth, 1, width of the hierarchy-level portion of addr.
- AccAddrWidth, 2, width of the accelerator-select portion of addr.
- HierLevel, 0, hierarchy level this unit belongs to (used only with the optional feature).
- ExtIdWidth, 2, width of the extended ID (1 + requester index bits).
- MaxOutstanding, 4, ID FIFO depth and maximum in-flight requests; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request ready.
- q_addr_i  in  HierAddrWidth+AccAddrWidth  request address.
- q_instr_i  in  32  offloaded instruction word.
- q_rs1_i  in  DataWidth  operand 1.
- q_rs2_i  in  DataWidth  operand 2.
- q_id_i  in  ExtIdWidth  extended request ID.
- p_valid_o  out  1  response valid.
- p_ready_i  in  1  response ready.
- p_data_o  out  DataWidth  result.
- p_error_o  out  1  response error flag.
- p_id_o  out  ExtIdWidth  echoed extended ID.
- core_req_valid_o  out  1  issue valid to core.
- core_req_ready_i  in  1  core accepts.
- core_instr_o  out  32  instruction forwarded to core.
- core_rs1_o  out  DataWidth  operand 1 forwarded to core.
- core_rs2_o  out  DataWidth  operand 2 forwarded to core.
- core_rsp_valid_i  in  1  core result valid (in issue order).
- core_rsp_ready_o  out  1  result accepted.
- core_rsp_data_i  in  DataWidth  core result.
- core_rsp_error_i  in  1  core error.
- overflow_o  out  1  sticky: core result arrived with ID FIFO empty.

Behaviour:
- Clock is clk_i; reset rst_i is synchronous, active-high.
- Reset values: FIFO empty, count=0, p_valid_o=0, p_data_o=0, p_error_o=0, p_id_o=0, overflow_o=0.
- Reset mid-operation discards all outstanding IDs and any held response; p_valid_o is 0 from the next edge.
- Request path is combinational pass-through: core_req_valid_o = q_valid_i && !full; q_ready_o = core_req_ready_i && !full.
- full is count==MaxOutstanding. A same-cycle pop does not free a slot for a push; ready is never derived from pop.
- On request handshake, push {q_id_i, drop=0} into the ID FIFO.
- Handshake rules: q_valid_i must hold until ready; p_valid_o holds until p_ready_i with payload stable.
- Response output register: core_rsp_ready_o = (!p_valid_o || p_ready_i) && !empty && !head.drop.
- On core result handshake: load p_data_o=core_rsp_data_i, p_error_o=core_rsp_error_i, p_id_o=head.id; set p_valid_o=1; pop the FIFO.
- Latency: one cycle from core result handshake to p_valid_o. Throughput: one response per cycle under continuous p_ready_i.
- If p_ready_i is seen and no new load occurs that cycle, p_valid_o clears next cycle.
- Simultaneous push and pop: count unchanged; pointers wrap modulo MaxOutstanding.
- Count width is idx_width(MaxOutstanding+1).
- core_rsp_valid_i while empty is a protocol violation: sets overflow_o (cleared only by reset). The result is not accepted.

Optional Feature:
- Macro: ACC_C_RESPONDER_LEVEL_CHECK_EN.
- When defined:
  - A request whose q_addr_i[HierAddrWidth+AccAddrWidth-1:AccAddrWidth] differs from HierLevel is accepted (q_ready_o = !full, independent of core_req_ready_i) but not forwarded to the core; core_req_valid_o=0 that cycle.
  - The request is pushed with drop=1.
  - When a drop=1 entry reaches the head and the output register is free, the block emits a response with p_data_o=0, p_error_o=1, p_id_o=head.id and pops, without a core handshake. This preserves order.
- When undefined: every request is forwarded to the core, drop is always 0, and its FIFO bit may be removed.

Decomposition:
- Shared package acc_c_responder_pkg: id-entry struct {id, drop}, and the count-width function (or reuse cf_math_pkg::idx_width).
- One sub-module: acc_c_id_fifo (parameterised depth/type, push/pop/full/empty, synchronous active-high reset).

Test Plan:
- Single op: q id=2'b10, rs1=5, rs2=7; core returns 12 two cycles later -> p_valid_o=1 one cycle after core handshake, p_data_o=12, p_id_o=2'b10, p_error_o=0.
- Backpressure: p_ready_i=0 for 5 cycles with 2 core results pending -> p payload stable; second result waits (core_rsp_ready_o=0); both delivered in order once ready.
- Full: 4 requests issued, core stalls results -> q_ready_o=0 on 5th. Release one result while the 5th is pending -> 5th accepted the cycle after the pop, not the same cycle.
- Reset mid-flight: 3 outstanding, rst_i=1 for one cycle -> next cycle p_valid_o=0, q_ready_o=core_req_ready_i, overflow_o=0.
- Orphan result: core_rsp_valid_i=1 with FIFO empty -> overflow_o=1 and stays 1; no response emitted.
- With ACC_C_RESPONDER_LEVEL_CHECK_EN, HierLevel=0: requests ids 01(level0), 11(level1) -> core sees one op; responses in order: id 01 with core data, then id 11 with data 0, error 1.

Source files
------------

// File: rtl/acc_c_responder_pkg.sv
// Shared types and helpers for the ACC_C accelerator-side responder.
package acc_c_responder_pkg;

    // Width of an index/counter able to hold values 0..n-1 (never less than 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Which source loads the response register in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CORE = 2'd1,
        SRC_DROP = 2'd2
    } rsp_src_e;

endpackage

// File: rtl/acc_c_responder_if.sv
// Request, response and core-side signals of one acc_c_responder instance.
// Valid/ready: a transfer happens on a clock edge where valid and ready are both 1;
// a source holds valid and keeps its payload stable until that edge.
interface acc_c_responder_if #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned HierAddrWidth = 1,
    parameter int unsigned AccAddrWidth  = 2,
    parameter int unsigned ExtIdWidth    = 2
);
    logic                                  q_valid_i;
    logic                                  q_ready_o;
    logic [HierAddrWidth+AccAddrWidth-1:0] q_addr_i;
    logic [31:0]                           q_instr_i;
    logic [DataWidth-1:0]                  q_rs1_i;
    logic [DataWidth-1:0]                  q_rs2_i;
    logic [ExtIdWidth-1:0]                 q_id_i;
    logic                                  p_valid_o;
    logic                                  p_ready_i;
    logic [DataWidth-1:0]                  p_data_o;
    logic                                  p_error_o;
    logic [ExtIdWidth-1:0]                 p_id_o;
    logic                                  core_req_valid_o;
    logic                                  core_req_ready_i;
    logic [31:0]                           core_instr_o;
    logic [DataWidth-1:0]                  core_rs1_o;
    logic [DataWidth-1:0]                  core_rs2_o;
    logic                                  core_rsp_valid_i;
    logic                                  core_rsp_ready_o;
    logic [DataWidth-1:0]                  core_rsp_data_i;
    logic                                  core_rsp_error_i;
    logic                                  overflow_o;

    // master: the environment (requester side plus accelerator core).
    modport master (
        output q_valid_i, q_addr_i, q_instr_i, q_rs1_i, q_rs2_i, q_id_i,
        output p_ready_i, core_req_ready_i,
        output core_rsp_valid_i, core_rsp_data_i, core_rsp_error_i,
        input  q_ready_o, p_valid_o, p_data_o, p_error_o, p_id_o,
        input  core_req_valid_o, core_instr_o, core_rs1_o, core_rs2_o,
        input  core_rsp_ready_o, overflow_o
    );

    // slave: the responder itself.
    modport slave (
        input  q_valid_i, q_addr_i, q_instr_i, q_rs1_i, q_rs2_i, q_id_i,
        input  p_ready_i, core_req_ready_i,
        input  core_rsp_valid_i, core_rsp_data_i, core_rsp_error_i,
        output q_ready_o, p_valid_o, p_data_o, p_error_o, p_id_o,
        output core_req_valid_o, core_instr_o, core_rs1_o, core_rs2_o,
        output core_rsp_ready_o, overflow_o
    );
endinterface

// File: rtl/acc_c_id_fifo.sv
// In-order FIFO of outstanding request IDs; Depth must be a power of two.
module acc_c_id_fifo
    import acc_c_responder_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = idx_width(Depth + 1);

    entry_t            mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/acc_c_responder.sv
// ACC_C accelerator-side endpoint: forwards operands to the core, re-attaches IDs to in-order results.
// Optional level check (drop + error response for foreign-level requests): ACC_C_RESPONDER_LEVEL_CHECK_EN.
module acc_c_responder
    import acc_c_responder_pkg::*;
#(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned HierAddrWidth  = 1,
    parameter int unsigned AccAddrWidth   = 2,
    parameter int unsigned HierLevel      = 0,
    parameter int unsigned ExtIdWidth     = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    acc_c_responder_if.slave   bus
);
    typedef struct packed {
        logic [ExtIdWidth-1:0] id;
        logic                  drop;
    } id_entry_t;

    id_entry_t             push_entry;
    id_entry_t             head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  level_ok;
    logic                  q_ready;
    logic                  out_free;
    rsp_src_e              rsp_src;

    logic                  p_valid_q;
    logic [DataWidth-1:0]  p_data_q;
    logic                  p_error_q;
    logic [ExtIdWidth-1:0] p_id_q;
    logic                  overflow_q;

`ifdef ACC_C_RESPONDER_LEVEL_CHECK_EN
    localparam logic [HierAddrWidth-1:0] LevelCfg = HierAddrWidth'(HierLevel);
    assign level_ok = (bus.q_addr_i[HierAddrWidth+AccAddrWidth-1:AccAddrWidth] == LevelCfg);
`else
    assign level_ok = 1'b1;
`endif

    // Request path is pure combinational pass-through; readiness never depends on a pop.
    assign q_ready              = !full && (bus.core_req_ready_i || !level_ok);
    assign bus.q_ready_o        = q_ready;
    assign bus.core_req_valid_o = bus.q_valid_i && !full && level_ok;
    assign bus.core_instr_o     = bus.q_instr_i;
    assign bus.core_rs1_o       = bus.q_rs1_i;
    assign bus.core_rs2_o       = bus.q_rs2_i;

    assign push       = bus.q_valid_i && q_ready;
    assign push_entry = '{id: bus.q_id_i, drop: !level_ok};

    acc_c_id_fifo #(
        .Depth   (MaxOutstanding),
        .entry_t (id_entry_t)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign out_free             = !p_valid_q || bus.p_ready_i;
    assign bus.core_rsp_ready_o = out_free && !empty && !head.drop;

    // A dropped head entry is answered locally, without waiting for the core.
    always_comb begin
        rsp_src = SRC_NONE;
        if (!empty && out_free) begin
            if (head.drop)                 rsp_src = SRC_DROP;
            else if (bus.core_rsp_valid_i) rsp_src = SRC_CORE;
        end
    end

    assign pop = (rsp_src != SRC_NONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_valid_q  <= 1'b0;
            p_data_q   <= '0;
            p_error_q  <= 1'b0;
            p_id_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (rsp_src)
                SRC_CORE: begin
                    p_valid_q <= 1'b1;
                    p_data_q  <= bus.core_rsp_data_i;
                    p_error_q <= bus.core_rsp_error_i;
                    p_id_q    <= head.id;
                end
                SRC_DROP: begin
                    p_valid_q <= 1'b1;
                    p_data_q  <= '0;
                    p_error_q <= 1'b1;
                    p_id_q    <= head.id;
                end
                default: begin
                    if (bus.p_ready_i) p_valid_q <= 1'b0;
                end
            endcase
            if (bus.core_rsp_valid_i && empty) overflow_q <= 1'b1;
        end
    end

    assign bus.p_valid_o  = p_valid_q;
    assign bus.p_data_o   = p_data_q;
    assign bus.p_error_o  = p_error_q;
    assign bus.p_id_o     = p_id_q;
    assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_acc_c_responder.sv
// Self-checking bench for acc_c_responder: directed scenarios plus a randomized queue-model run.
module tb_acc_c_responder;
  localparam int unsigned DW   = 32;
  localparam int unsigned HAW  = 1;
  localparam int unsigned AAW  = 2;
  localparam int unsigned EIW  = 2;
  localparam int unsigned MAXO = 4;
  localparam int unsigned PW   = EIW + 1 + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  acc_c_responder_if #(.DataWidth(DW), .HierAddrWidth(HAW), .AccAddrWidth(AAW), .ExtIdWidth(EIW)) bus ();

  acc_c_responder #(
    .DataWidth(DW), .HierAddrWidth(HAW), .AccAddrWidth(AAW),
    .HierLevel(0), .ExtIdWidth(EIW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.q_valid_i        = 1'b0;
    bus.q_addr_i         = '0;
    bus.q_instr_i        = '0;
    bus.q_rs1_i          = '0;
    bus.q_rs2_i          = '0;
    bus.q_id_i           = '0;
    bus.p_ready_i        = 1'b0;
    bus.core_req_ready_i = 1'b0;
    bus.core_rsp_valid_i = 1'b0;
    bus.core_rsp_data_i  = '0;
    bus.core_rsp_error_i = 1'b0;
  endtask

  // driver: present a request (caller advances the clock)
  task automatic drive_req(input logic [EIW-1:0] id, input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                           input logic [HAW+AAW-1:0] addr);
    bus.q_valid_i = 1'b1;
    bus.q_id_i    = id;
    bus.q_rs1_i   = rs1;
    bus.q_rs2_i   = rs2;
    bus.q_instr_i = {16'hC0DE, 14'd0, id};
    bus.q_addr_i  = addr;
  endtask

  task automatic drive_rsp(input logic [DW-1:0] data, input logic err);
    bus.core_rsp_valid_i = 1'b1;
    bus.core_rsp_data_i  = data;
    bus.core_rsp_error_i = err;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.core_req_ready_i = 1'b1;
    next(); next();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_p_valid: got %0b want 0", bus.p_valid_o); end
    n_cmp++; if (bus.p_data_o !== '0) begin n_err++; $display("FAIL reset_p_data: got %0h want 0", bus.p_data_o); end
    n_cmp++; if (bus.p_error_o !== 1'b0) begin n_err++; $display("FAIL reset_p_error: got %0b want 0", bus.p_error_o); end
    n_cmp++; if (bus.p_id_o !== '0) begin n_err++; $display("FAIL reset_p_id: got %0h want 0", bus.p_id_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow_o); end
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_core_rsp_ready: got %0b want 0", bus.core_rsp_ready_o); end
    n_cmp++; if (bus.q_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_q_ready: got %0b want 1", bus.q_ready_o); end
    next();
  endtask

  task automatic test_single_op();
    bus.core_req_ready_i = 1'b1;
    bus.p_ready_i = 1'b1;
    drive_req(2'b10, 32'd5, 32'd7, '0);
    @(negedge clk);
    n_cmp++; if (bus.core_req_valid_o !== 1'b1) begin n_err++; $display("FAIL single_core_req_valid: got %0b want 1", bus.core_req_valid_o); end
    n_cmp++; if (bus.q_ready_o !== 1'b1) begin n_err++; $display("FAIL single_q_ready: got %0b want 1", bus.q_ready_o); end
    n_cmp++; if ({bus.core_rs1_o, bus.core_rs2_o} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL single_operands: got %0h/%0h want 5/7", bus.core_rs1_o, bus.core_rs2_o); end
    n_cmp++; if (bus.core_instr_o !== 32'hC0DE_0002) begin n_err++; $display("FAIL single_instr: got %0h want c0de0002", bus.core_instr_o); end
    next();
    bus.q_valid_i = 1'b0;
    next();
    drive_rsp(32'd12, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b1) begin n_err++; $display("FAIL single_core_rsp_ready: got %0b want 1", bus.core_rsp_ready_o); end
    next();
    bus.core_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o} !== {1'b1, 2'b10, 1'b0, 32'd12})
      begin n_err++; $display("FAIL single_response: got v=%0b id=%0h err=%0b data=%0d want v=1 id=2 err=0 data=12",
                              bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o); end
    next();
    @(negedge clk);
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL single_p_valid_clear: got %0b want 0", bus.p_valid_o); end
    next();
  endtask

  task automatic test_backpressure();
    bus.p_ready_i = 1'b0;
    bus.core_req_ready_i = 1'b1;
    drive_req(2'd1, 32'd1, 32'd1, '0); next();
    drive_req(2'd3, 32'd2, 32'd2, '0); next();
    bus.q_valid_i = 1'b0;
    drive_rsp(32'd100, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_first_accept: got %0b want 1", bus.core_rsp_ready_o); end
    next();
    drive_rsp(32'd200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o} !== {1'b1, 2'd1, 1'b0, 32'd100})
        begin n_err++; $display("FAIL bp_hold_payload: got v=%0b id=%0h err=%0b data=%0d want v=1 id=1 err=0 data=100",
                                bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o); end
      n_cmp++; if (bus.core_rsp_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_second_waits: got %0b want 0", bus.core_rsp_ready_o); end
      next();
    end
    bus.p_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", bus.core_rsp_ready_o); end
    next();
    bus.core_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o} !== {1'b1, 2'd3, 1'b1, 32'd200})
      begin n_err++; $display("FAIL bp_second_response: got v=%0b id=%0h err=%0b data=%0d want v=1 id=3 err=1 data=200",
                              bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o); end
    next();
    @(negedge clk);
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %0b want 0", bus.p_valid_o); end
    next();
  endtask

  task automatic test_full();
    logic [EIW-1:0] exp_ids [4];
    exp_ids = '{2'd1, 2'd2, 2'd3, 2'd2};
    bus.p_ready_i = 1'b1;
    bus.core_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(EIW'(i), DW'(i), DW'(i), '0);
      @(negedge clk);
      n_cmp++; if (bus.q_ready_o !== 1'b1) begin n_err++; $display("FAIL full_fill_ready%0d: got %0b want 1", i, bus.q_ready_o); end
      next();
    end
    drive_req(2'd2, 32'd9, 32'd9, '0);
    @(negedge clk);
    n_cmp++; if ({bus.q_ready_o, bus.core_req_valid_o} !== 2'b00) begin n_err++; $display("FAIL full_blocked: got ready/valid=%0b%0b want 00", bus.q_ready_o, bus.core_req_valid_o); end
    next();
    drive_rsp(32'hA0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b1) begin n_err++; $display("FAIL full_pop_ready: got %0b want 1", bus.core_rsp_ready_o); end
    n_cmp++; if (bus.q_ready_o !== 1'b0) begin n_err++; $display("FAIL full_no_same_cycle: got %0b want 0", bus.q_ready_o); end
    next();
    bus.core_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.q_ready_o !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got %0b want 1", bus.q_ready_o); end
    n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_data_o} !== {1'b1, 2'd0, 32'hA0}) begin n_err++; $display("FAIL full_first_rsp: got v=%0b id=%0h data=%0h want v=1 id=0 data=a0", bus.p_valid_o, bus.p_id_o, bus.p_data_o); end
    next();
    bus.q_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rsp(DW'(32'hA1 + i), 1'b0);
      @(negedge clk);
      n_cmp++; if (bus.core_rsp_ready_o !== 1'b1) begin n_err++; $display("FAIL full_drain_ready%0d: got %0b want 1", i, bus.core_rsp_ready_o); end
      next();
      bus.core_rsp_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_data_o} !== {1'b1, exp_ids[i], DW'(32'hA1 + i)})
        begin n_err++; $display("FAIL full_drain_rsp%0d: got v=%0b id=%0h data=%0h want v=1 id=%0h data=%0h",
                                i, bus.p_valid_o, bus.p_id_o, bus.p_data_o, exp_ids[i], 32'hA1 + i); end
      next();
    end
  endtask

  task automatic test_reset_mid();
    bus.p_ready_i = 1'b0;
    bus.core_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(EIW'(i), DW'(i), DW'(i), '0);
      next();
    end
    bus.q_valid_i = 1'b0;
    drive_rsp(32'h55, 1'b1);
    next();
    bus.core_rsp_valid_i = 1'b0;
    rst = 1'b1;
    bus.core_req_ready_i = 1'b0;
    next();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_p_valid: got %0b want 0", bus.p_valid_o); end
    n_cmp++; if (bus.q_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_q_ready_lo: got %0b want 0", bus.q_ready_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow: got %0b want 0", bus.overflow_o); end
    bus.core_rsp_valid_i = 1'b0;
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_fifo_empty: got %0b want 0", bus.core_rsp_ready_o); end
    next();
    bus.core_req_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.q_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_q_ready_hi: got %0b want 1", bus.q_ready_o); end
    next();
    bus.p_ready_i = 1'b1;
  endtask

`ifdef ACC_C_RESPONDER_LEVEL_CHECK_EN
  task automatic test_level_check();
    bus.p_ready_i = 1'b1;
    bus.core_req_ready_i = 1'b1;
    drive_req(2'b01, 32'd20, 32'd22, 3'b000);
    @(negedge clk);
    n_cmp++; if (bus.core_req_valid_o !== 1'b1) begin n_err++; $display("FAIL lvl_local_fwd: got %0b want 1", bus.core_req_valid_o); end
    next();
    bus.core_req_ready_i = 1'b0;
    drive_req(2'b11, 32'd1, 32'd1, 3'b100);
    @(negedge clk);
    n_cmp++; if ({bus.core_req_valid_o, bus.q_ready_o} !== 2'b01) begin n_err++; $display("FAIL lvl_foreign_drop: got valid/ready=%0b%0b want 01", bus.core_req_valid_o, bus.q_ready_o); end
    next();
    bus.q_valid_i = 1'b0;
    drive_rsp(32'd42, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b1) begin n_err++; $display("FAIL lvl_core_ready: got %0b want 1", bus.core_rsp_ready_o); end
    next();
    bus.core_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o} !== {1'b1, 2'b01, 1'b0, 32'd42})
      begin n_err++; $display("FAIL lvl_rsp_local: got v=%0b id=%0h err=%0b data=%0d want v=1 id=1 err=0 data=42", bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o); end
    next();
    @(negedge clk);
    n_cmp++; if ({bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o} !== {1'b1, 2'b11, 1'b1, 32'd0})
      begin n_err++; $display("FAIL lvl_rsp_drop: got v=%0b id=%0h err=%0b data=%0d want v=1 id=3 err=1 data=0", bus.p_valid_o, bus.p_id_o, bus.p_error_o, bus.p_data_o); end
    next();
    @(negedge clk);
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL lvl_drained: got %0b want 0", bus.p_valid_o); end
    next();
  endtask
`endif

  // Random traffic checked against a queue model: outstanding IDs, results the
  // core still owes, and a scoreboard of responses in delivery order.
  task automatic test_random();
    logic [EIW-1:0] id_q [$];
    logic [PW-1:0]  exp_q [$];
    int             core_owed = 0;
    logic           m_pv = 1'b0;
    logic           q_hold = 1'b0;
    logic           c_hold = 1'b0;
    logic           m_full, m_qr, m_crr, q_hs, c_hs, p_hs;
    idle_inputs();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!q_hold) begin
        if (cyc < 550 && $urandom_range(0, 1) == 1)
          drive_req(EIW'($urandom_range(0, 3)), $urandom, $urandom, {1'b0, 2'($urandom_range(0, 3))});
        else
          bus.q_valid_i = 1'b0;
      end
      bus.core_req_ready_i = ($urandom_range(0, 9) < 7);
      bus.p_ready_i        = ($urandom_range(0, 9) < 7);
      if (!c_hold) begin
        if (core_owed > 0 && $urandom_range(0, 9) < 6) drive_rsp($urandom, 1'($urandom_range(0, 1)));
        else bus.core_rsp_valid_i = 1'b0;
      end
      @(negedge clk);
      m_full = (id_q.size() == MAXO);
      m_qr   = bus.core_req_ready_i && !m_full;
      m_crr  = (!m_pv || bus.p_ready_i) && (id_q.size() != 0);
      n_cmp++; if (bus.q_ready_o !== m_qr) begin n_err++; $display("FAIL rnd_q_ready c%0d: got %0b want %0b", cyc, bus.q_ready_o, m_qr); end
      n_cmp++; if (bus.core_req_valid_o !== (bus.q_valid_i && !m_full)) begin n_err++; $display("FAIL rnd_core_req_valid c%0d: got %0b want %0b", cyc, bus.core_req_valid_o, bus.q_valid_i && !m_full); end
      n_cmp++; if (bus.core_rsp_ready_o !== m_crr) begin n_err++; $display("FAIL rnd_core_rsp_ready c%0d: got %0b want %0b", cyc, bus.core_rsp_ready_o, m_crr); end
      n_cmp++; if (bus.p_valid_o !== m_pv) begin n_err++; $display("FAIL rnd_p_valid c%0d: got %0b want %0b", cyc, bus.p_valid_o, m_pv); end
      if (m_pv && exp_q.size() != 0) begin
        n_cmp++; if ({bus.p_id_o, bus.p_error_o, bus.p_data_o} !== exp_q[0])
          begin n_err++; $display("FAIL rnd_payload c%0d: got %0h want %0h", cyc, {bus.p_id_o, bus.p_error_o, bus.p_data_o}, exp_q[0]); end
      end
      n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL rnd_overflow c%0d: got %0b want 0", cyc, bus.overflow_o); end
      q_hs = bus.q_valid_i && m_qr;
      c_hs = bus.core_rsp_valid_i && m_crr;
      p_hs = m_pv && bus.p_ready_i;
      if (p_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (c_hs) begin
        exp_q.push_back({id_q.pop_front(), bus.core_rsp_error_i, bus.core_rsp_data_i});
        core_owed--;
        m_pv = 1'b1;
      end else if (p_hs) begin
        m_pv = 1'b0;
      end
      if (q_hs) begin
        id_q.push_back(bus.q_id_i);
        core_owed++;
      end
      q_hold = bus.q_valid_i && !q_hs;
      c_hold = bus.core_rsp_valid_i && !c_hs;
      next();
    end
    idle_inputs();
  endtask

  task automatic test_orphan();
    idle_inputs();
    rst = 1'b1;
    next();
    rst = 1'b0;
    drive_rsp(32'h77, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.core_rsp_ready_o !== 1'b0) begin n_err++; $display("FAIL orphan_not_accepted: got %0b want 0", bus.core_rsp_ready_o); end
    next();
    bus.core_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL orphan_overflow_set: got %0b want 1", bus.overflow_o); end
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL orphan_no_response: got %0b want 0", bus.p_valid_o); end
    next(); next(); next();
    @(negedge clk);
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL orphan_overflow_sticky: got %0b want 1", bus.overflow_o); end
    n_cmp++; if (bus.p_valid_o !== 1'b0) begin n_err++; $display("FAIL orphan_still_idle: got %0b want 0", bus.p_valid_o); end
    next();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_op();
    test_backpressure();
    test_full();
    test_reset_mid();
`ifdef ACC_C_RESPONDER_LEVEL_CHECK_EN
    test_level_check();
`endif
    test_random();
    test_orphan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
